// File: rtl/mult18_share_arb.sv
// mult18_share_arb: round-robin arbiter that shares one iterative 18x18
// multiplier (start/done handshake, 36-bit product) between NUM_REQ clients.
// Requests are serialised IDLE -> ISSUE -> WAIT -> RESP; every output is a flop.
// Optional build macro: MULT_ARB_TIMEOUT_EN aborts WAIT after TIMEOUT_CYC cycles
// without mult_done and returns resp_p=0 with resp_err=1.
module mult18_share_arb #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned IDW         = $clog2(NUM_REQ),
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*18-1:0] req_a,
  input  logic [NUM_REQ*18-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [35:0]           resp_p,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  mult_start,
  output logic [17:0]           mult_a,
  output logic [17:0]           mult_b,
  input  logic [35:0]           mult_p,
  input  logic                  mult_done
);

  // Elaboration-time guard on the supported parameter range.
  if (NUM_REQ < 2 || NUM_REQ > 8 || IDW != $clog2(NUM_REQ) || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("mult18_share_arb: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] pick;
  logic           any_req;
  logic [IDW-1:0] next_ptr;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  // Index rr_ptr+off, wrapped into 0..NUM_REQ-1 (NUM_REQ need not be a power of two).
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // Round-robin pick: first asserted requester at or above rr_ptr, wrapping.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      if (!any_req && req_valid[wrap_add(rr_ptr, off)]) begin
        pick    = wrap_add(rr_ptr, off);
        any_req = 1'b1;
      end
    end
  end

  // Pointer advances past the requester just served.
  always_comb begin
    next_ptr = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + IDW'(1);
  end

  // Sequencer: pulses are cleared every cycle and set only on the relevant transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_p     <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      mult_start <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      req_ready  <= '0;
      resp_valid <= '0;
      resp_err   <= 1'b0;
      mult_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant           <= pick;
            mult_a          <= req_a[18*pick +: 18];
            mult_b          <= req_b[18*pick +: 18];
            req_ready[pick] <= 1'b1;
            busy            <= 1'b1;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mult_start <= 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (mult_done) begin
            resp_p            <= mult_p;
            resp_valid[grant] <= 1'b1;
            state             <= S_RESP;
          end
`ifdef MULT_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            resp_p            <= '0;
            resp_err          <= 1'b1;
            resp_valid[grant] <= 1'b1;
            state             <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        S_RESP: begin
          rr_ptr <= next_ptr;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
